// File: rtl/click_decoder.sv
// -----------------------------------------------------------------------------
// click_decoder
//
// Classifies one-cycle key pulses into single / double (and optionally triple)
// clicks. A click sequence opens on the first pulse; every later pulse must
// arrive within WIN cycles of the previous one to extend the sequence. When
// the window expires, or the maximum click count is reached, the sequence
// closes. The matching click output is then pulsed for one cycle.
//
// Optional feature macro: CLICK_TRIPLE_EN
//   undefined : a second pulse closes the sequence as a double click;
//               state TWO is unreachable and triple_click is tied to 0.
//   defined   : a second pulse moves to TWO; a third pulse gives a triple
//               click, and a window expiry in TWO gives a double click.
//
// Parameters
//   sim          0: WIN = 25_000_000 cycles (0.25 s at 100 MHz)
//                1: WIN = 8 cycles (simulation)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   pulse_in     one-cycle key pulse (held high N cycles = N pulses)
//   single_click one-cycle pulse, single click classified
//   double_click one-cycle pulse, double click classified
//   triple_click one-cycle pulse, triple click classified
//   busy         high while a click sequence is open
//   click_count  saturating count of accepted pulse_in cycles
// -----------------------------------------------------------------------------
module click_decoder #(
    parameter int sim = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pulse_in,
    output logic       single_click,
    output logic       double_click,
    output logic       triple_click,
    output logic       busy,
    output logic [7:0] click_count
);

    localparam int          WIN      = (sim != 0) ? 8 : 25_000_000;
    localparam logic [24:0] WIN_LAST = 25'(WIN - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ONE  = 2'd1;
    localparam logic [1:0] TWO  = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic [24:0] cnt_reg, cnt_next;
    logic        single_reg, single_next;
    logic        double_reg, double_next;
    logic [7:0]  count_reg, count_next;
`ifdef CLICK_TRIPLE_EN
    logic        triple_reg, triple_next;
`endif

    // The pulse is tested before the timeout in every state, so a pulse that
    // lands on the last window cycle extends the sequence instead of closing it.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        single_next = 1'b0;
        double_next = 1'b0;
`ifdef CLICK_TRIPLE_EN
        triple_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (pulse_in) begin
                    state_next = ONE;
                    cnt_next   = '0;
                end
            end
            ONE: begin
                if (pulse_in) begin
                    cnt_next = '0;
`ifdef CLICK_TRIPLE_EN
                    state_next = TWO;
`else
                    state_next  = IDLE;
                    double_next = 1'b1;
`endif
                end else if (cnt_reg == WIN_LAST) begin
                    state_next  = IDLE;
                    cnt_next    = '0;
                    single_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 25'd1;
                end
            end
            TWO: begin
`ifdef CLICK_TRIPLE_EN
                if (pulse_in) begin
                    state_next  = IDLE;
                    cnt_next    = '0;
                    triple_next = 1'b1;
                end else if (cnt_reg == WIN_LAST) begin
                    state_next  = IDLE;
                    cnt_next    = '0;
                    double_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 25'd1;
                end
`else
                // Unreachable in this build; recover to IDLE.
                state_next = IDLE;
                cnt_next   = '0;
`endif
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Saturating pulse counter, independent of the FSM.
    always_comb begin
        count_next = count_reg;
        if (pulse_in && (count_reg != 8'hFF)) begin
            count_next = count_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            single_reg <= 1'b0;
            double_reg <= 1'b0;
            count_reg  <= '0;
`ifdef CLICK_TRIPLE_EN
            triple_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            single_reg <= single_next;
            double_reg <= double_next;
            count_reg  <= count_next;
`ifdef CLICK_TRIPLE_EN
            triple_reg <= triple_next;
`endif
        end
    end

    assign single_click = single_reg;
    assign double_click = double_reg;
`ifdef CLICK_TRIPLE_EN
    assign triple_click = triple_reg;
`else
    assign triple_click = 1'b0;
`endif
    assign busy        = (state_reg != IDLE);
    assign click_count = count_reg;

endmodule

// File: tb/tb_click_decoder.sv
// -----------------------------------------------------------------------------
// tb_click_decoder
//
// Directed bench for click_decoder with sim=1 (WIN = 8). Stimulus pushes the
// expected click events (kind, absolute cycle) into a queue; an independent
// monitor pops and compares whenever a click output is seen. Expectations
// follow CLICK_TRIPLE_EN so the bench works for either build.
// -----------------------------------------------------------------------------
module tb_click_decoder;

    localparam int K_SINGLE = 1;
    localparam int K_DOUBLE = 2;
    localparam int K_TRIPLE = 3;

    logic       clk;
    logic       reset;
    logic       pulse_in;
    logic       single_click;
    logic       double_click;
    logic       triple_click;
    logic       busy;
    logic [7:0] click_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    click_decoder #(.sim(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .pulse_in     (pulse_in),
        .single_click (single_click),
        .double_click (double_click),
        .triple_click (triple_click),
        .busy         (busy),
        .click_count  (click_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle k spans posedge k to posedge k+1.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every observed click against the queued expectation.
    always @(negedge clk) begin
        int   n;
        int   kind;
        exp_t e;
        if (reset) begin
            n = int'(single_click) + int'(double_click) + int'(triple_click);
            if (n > 1) begin
                checks++;
                errors++;
                $display("FAIL onehot: cycle %0d got %0d click outputs high, required at most 1", cyc, n);
            end else if (n == 1) begin
                kind = single_click ? K_SINGLE : (double_click ? K_DOUBLE : K_TRIPLE);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL click: unexpected kind %0d at cycle %0d, required none", kind, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != kind || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL click: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                                 kind, cyc, e.kind, e.cyc);
                    end else begin
                        $display("click kind %0d at cycle %0d ok", kind, cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end else begin
            $display("check %s = %0d ok", name, got);
        end
    endtask

    task automatic push_exp(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Drive pulse_in for the current cycle, then advance to 1 time unit past
    // the next rising edge.
    task automatic tick(input bit p);
        pulse_in = p;
        @(posedge clk);
        #1;
        pulse_in = 1'b0;
    endtask

    // Pulses at relative cycles p0/p1/p2 (-1 = unused) over len cycles.
    task automatic run_seq(input int p0, input int p1, input int p2, input int len);
        for (int i = 0; i < len; i++) begin
            tick(i == p0 || i == p1 || i == p2);
        end
    endtask

    initial begin
        int t0;
        reset    = 1'b0;
        pulse_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_count", int'(click_count), 0);
        chk("reset_clicks", int'(single_click | double_click | triple_click), 0);
        reset = 1'b1;
        tick(1'b0);
        tick(1'b0);

        // Single pulse: busy in cycles 1..8, single_click in cycle 9.
        t0 = cyc;
        push_exp(K_SINGLE, t0 + 9);
        for (int i = 0; i < 12; i++) begin
            tick(i == 0);
            chk($sformatf("single_busy_c%0d", i + 1), int'(busy), (i + 1 >= 1 && i + 1 <= 8) ? 1 : 0);
        end
        run_seq(-1, -1, -1, 5);
        chk("count_after_single", int'(click_count), 1);

        // Pulses at 0 and 4.
        t0 = cyc;
`ifdef CLICK_TRIPLE_EN
        push_exp(K_DOUBLE, t0 + 13);
`else
        push_exp(K_DOUBLE, t0 + 5);
`endif
        run_seq(0, 4, -1, 25);
        chk("count_after_double", int'(click_count), 3);

        // Pulses at 0 and 10: two separate single clicks.
        t0 = cyc;
        push_exp(K_SINGLE, t0 + 9);
        push_exp(K_SINGLE, t0 + 19);
        run_seq(0, 10, -1, 25);
        chk("count_after_two_singles", int'(click_count), 5);

        // Pulses at 0, 3 and 6.
        t0 = cyc;
`ifdef CLICK_TRIPLE_EN
        push_exp(K_TRIPLE, t0 + 7);
`else
        push_exp(K_DOUBLE, t0 + 4);
        push_exp(K_SINGLE, t0 + 15);
`endif
        run_seq(0, 3, 6, 25);
        chk("count_after_triple", int'(click_count), 8);

        // Pulses at 0 and 3 only.
        t0 = cyc;
`ifdef CLICK_TRIPLE_EN
        push_exp(K_DOUBLE, t0 + 12);
`else
        push_exp(K_DOUBLE, t0 + 4);
`endif
        run_seq(0, 3, -1, 25);

        // Second pulse at cycle 8, coinciding with cnt == WIN-1.
        t0 = cyc;
`ifdef CLICK_TRIPLE_EN
        push_exp(K_DOUBLE, t0 + 17);
`else
        push_exp(K_DOUBLE, t0 + 9);
`endif
        run_seq(0, 8, -1, 25);

        // pulse_in held high for two cycles counts as two pulses.
        t0 = cyc;
`ifdef CLICK_TRIPLE_EN
        push_exp(K_DOUBLE, t0 + 10);
`else
        push_exp(K_DOUBLE, t0 + 2);
`endif
        run_seq(0, 1, -1, 25);
        chk("count_after_held", int'(click_count), 14);

        // Reset at cycle 4 of an open sequence: no click afterwards.
        run_seq(0, -1, -1, 4);
        chk("pre_reset_busy", int'(busy), 1);
        reset = 1'b0;
        #1;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_count", int'(click_count), 0);
        chk("midreset_clicks", int'(single_click | double_click | triple_click), 0);
        tick(1'b0);
        tick(1'b0);
        reset = 1'b1;
        run_seq(-1, -1, -1, 20);
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_count", int'(click_count), 0);

        // 300 pulses spaced 20 cycles apart: count saturates at 255.
        for (int k = 0; k < 300; k++) begin
            t0 = cyc;
            push_exp(K_SINGLE, t0 + 9);
            run_seq(0, -1, -1, 20);
            if (k == 254) chk("count_at_255", int'(click_count), 255);
        end
        chk("count_saturated", int'(click_count), 255);

        run_seq(-1, -1, -1, 20);
        chk("pending_expectations", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running at cycle %0d, required completion", cyc);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/click_decoder.md
CLICK_DECODER -- requirements
Module: click_decoder

Interface
REQ-001 SHALL have parameter sim, default 0, selecting the click window: 0 gives WIN = 25_000_000 cycles (0.25 s at 100 MHz); 1 gives WIN = 8 cycles.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port pulse_in, input, 1 bit: one-cycle key pulse from the button processing unit's ButtonOut.
REQ-005 SHALL have port single_click, output, 1 bit: one-cycle pulse when a single click is classified.
REQ-006 SHALL have port double_click, output, 1 bit: one-cycle pulse when a double click is classified.
REQ-007 SHALL have port triple_click, output, 1 bit: one-cycle pulse when a triple click is classified (macro-dependent).
REQ-008 SHALL have port busy, output, 1 bit: high while a click sequence is open (state not IDLE).
REQ-009 SHALL have port click_count, output, 8 bits: total accepted pulse_in cycles, saturating.

Function
REQ-010 SHALL implement the FSM states IDLE, ONE and TWO, plus a 25-bit window counter cnt.
REQ-011 SHALL, in IDLE with pulse_in=1, go to ONE with cnt=0.
REQ-012 SHALL, in ONE or TWO with pulse_in=0 and cnt<WIN-1, increment cnt by 1 per cycle.
REQ-013 SHALL, in ONE with pulse_in=0 and cnt==WIN-1, go to IDLE and assert single_click on the next cycle.
REQ-014 SHALL, in ONE with pulse_in=1, handle the second click per the Configuration section.
REQ-015 SHALL treat pulse_in=1 and a cnt==WIN-1 timeout in the same cycle as a click inside the window: the pulse wins and no timeout output is produced.
REQ-016 SHALL register all click outputs: each is high for exactly 1 cycle, the cycle after the deciding edge, and at most one click output is high in any cycle.
REQ-017 SHALL drive busy combinationally from the state register: busy=1 exactly when state is not IDLE.
REQ-018 SHALL increment click_count by 1 on every cycle with pulse_in=1, and hold it at 8'hFF once reached (no wrap).
REQ-019 SHALL treat pulse_in held high for N cycles as N pulses (defined behaviour, not an error).
REQ-020 SHALL make a pulse_in in the cycle after a sequence closes start a new sequence from IDLE.

Reset
REQ-021 SHALL, while reset=0, asynchronously force state=IDLE, cnt=0, click_count=0, and single_click, double_click and triple_click to 0; busy is then 0.
REQ-022 SHALL make reset mid-sequence discard the open sequence with no click output emitted, and resume normal operation on the first clk edge after reset returns to 1.

Configuration
REQ-023 SHALL use the macro CLICK_TRIPLE_EN to compile triple-click detection in or out.
REQ-024 SHALL, without CLICK_TRIPLE_EN, on pulse_in=1 in ONE, go to IDLE and assert double_click on the next cycle; state TWO is unreachable and triple_click is tied to 0.
REQ-025 SHALL, with CLICK_TRIPLE_EN, on pulse_in=1 in ONE, go to TWO with cnt=0.
REQ-026 SHALL, with CLICK_TRIPLE_EN, in TWO with pulse_in=0 and cnt==WIN-1, go to IDLE and assert double_click on the next cycle.
REQ-027 SHALL, with CLICK_TRIPLE_EN, in TWO with pulse_in=1, go to IDLE and assert triple_click on the next cycle.

Verification (sim=1, WIN=8, pulse at cycle 0 unless stated)
REQ-028 SHALL cover: single pulse -> busy=1 in cycles 1-8, single_click=1 in cycle 9 only, click_count=1.
REQ-029 SHALL cover: pulses at cycles 0 and 4, macro off -> double_click=1 in cycle 5 only, no single_click, click_count=2.
REQ-030 SHALL cover: pulses at cycles 0 and 10 -> single_click in cycle 9, then a second single_click in cycle 19.
REQ-031 SHALL cover: macro on, pulses at cycles 0, 3 and 6 -> triple_click=1 in cycle 7 only; pulses at 0 and 3 only -> double_click in cycle 12.
REQ-032 SHALL cover: pulse at cycle 8 coinciding with cnt==7 -> no single_click; macro off gives double_click in cycle 9.
REQ-033 SHALL cover: reset low at cycle 4 of an open sequence -> all outputs 0 immediately, no click output afterwards; 300 pulses spaced 20 cycles apart -> click_count=255.
